// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer peripheral: register offsets, CTRL bit
// positions and the byte-masked merge used by bus responders.
package bus_timer_pkg;

   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_PRESCALE = 3'd1;
   localparam logic [2:0] REG_MTIME_LO = 3'd2;
   localparam logic [2:0] REG_MTIME_HI = 3'd3;
   localparam logic [2:0] REG_CMP_LO   = 3'd4;
   localparam logic [2:0] REG_CMP_HI   = 3'd5;
   localparam logic [2:0] REG_STATUS   = 3'd6;

   localparam int CTRL_EN           = 0;
   localparam int CTRL_IRQ_EN       = 1;
   localparam int CTRL_CLR_ON_MATCH = 2;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wmask);
      logic [31:0] merged;
      merged = old_val;
      for (int i = 0; i < 4; i++) begin
         if (wmask[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for bus_timer: counts 0..i_prescale while enabled and emits a
// one-cycle tick on the wrap. Freezing (i_en=0) keeps the count.
module timer_prescaler #(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_en,
   input  logic [PRESCALE_W-1:0] i_prescale,
   output logic                  o_tick
);

   logic [PRESCALE_W-1:0] r_cnt;

   assign o_tick = i_en && (r_cnt == i_prescale);

   always_ff @(posedge clk) begin
      if (rst)         r_cnt <= '0;
      else if (o_tick) r_cnt <= '0;
      else if (i_en)   r_cnt <= r_cnt + PRESCALE_W'(1);
   end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 64-bit timer/compare responder: single-cycle bus handshake,
// prescaled mtime counter, compare with sticky PENDING and level irq.
module bus_timer
   import bus_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
   parameter int          PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wmask,
   input  logic        wen,
   input  logic        ren,
   output logic [31:0] rdata,
   output logic        done,
   output logic        active,
   output logic        irq
);

   logic [2:0]            r_ctrl;
   logic [PRESCALE_W-1:0] r_prescale;
   logic [63:0]           r_mtime;
   logic [63:0]           r_cmp;
   logic [31:0]           r_hi_shadow;
   logic                  r_pending;
   logic                  r_done;
   logic [31:0]           r_rdata;
   logic                  r_irq;

   logic        w_accept, w_wr, w_rd, w_tick, w_eq, w_set, w_w1c;
   logic [2:0]  w_off;
   logic [63:0] w_mtime_inc, w_mtime_nxt;
   logic [31:0] w_rd_val, w_ctrl_mrg, w_pre_mrg;
   logic        w_unused;

   // BASE_ADDR is 32-byte aligned, so the window is a match on addr[31:5].
   assign active   = (addr[31:5] == BASE_ADDR[31:5]);
   assign w_accept = active && (ren || wen) && !r_done;
   assign w_wr     = w_accept && wen;
   assign w_rd     = w_accept && ren && !wen;
   assign w_off    = addr[4:2];

   assign done  = r_done;
   assign rdata = r_rdata;
   assign irq   = r_irq;

   timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk        (clk),
      .rst        (rst),
      .i_en       (r_ctrl[CTRL_EN]),
      .i_prescale (r_prescale),
      .o_tick     (w_tick)
   );

   assign w_eq        = (r_mtime == r_cmp);
   assign w_mtime_inc = !w_tick ? r_mtime :
                        (r_ctrl[CTRL_CLR_ON_MATCH] && w_eq) ? 64'd0 : r_mtime + 64'd1;
   assign w_set       = (r_mtime >= r_cmp) || (w_tick && r_ctrl[CTRL_CLR_ON_MATCH] && w_eq);
   assign w_w1c       = w_wr && (w_off == REG_STATUS) && wmask[0] && wdata[0];
   assign w_ctrl_mrg  = byte_merge({29'd0, r_ctrl}, wdata, wmask);
   assign w_pre_mrg   = byte_merge(32'(r_prescale), wdata, wmask);
   assign w_unused    = &{1'b0, addr[1:0], w_ctrl_mrg[31:3], w_pre_mrg[31:PRESCALE_W]};

   // Software bytes override the ticked value; untouched bytes keep the tick.
   always_comb begin
      w_mtime_nxt = w_mtime_inc;
      if (w_wr && w_off == REG_MTIME_LO)
         w_mtime_nxt[31:0] = byte_merge(w_mtime_inc[31:0], wdata, wmask);
      if (w_wr && w_off == REG_MTIME_HI)
         w_mtime_nxt[63:32] = byte_merge(w_mtime_inc[63:32], wdata, wmask);
   end

   always_comb begin
      w_rd_val = 32'd0;
      case (w_off)
         REG_CTRL:     w_rd_val = {29'd0, r_ctrl};
         REG_PRESCALE: w_rd_val = 32'(r_prescale);
         REG_MTIME_LO: w_rd_val = r_mtime[31:0];
         REG_MTIME_HI: w_rd_val = r_hi_shadow;
         REG_CMP_LO:   w_rd_val = r_cmp[31:0];
         REG_CMP_HI:   w_rd_val = r_cmp[63:32];
         REG_STATUS:   w_rd_val = {31'd0, r_pending};
         default:      w_rd_val = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctrl      <= '0;
         r_prescale  <= '0;
         r_mtime     <= '0;
         r_cmp       <= '0;
         r_hi_shadow <= '0;
         r_pending   <= 1'b0;
         r_done      <= 1'b0;
         r_rdata     <= '0;
         r_irq       <= 1'b0;
      end else begin
         r_done    <= w_accept;
         r_rdata   <= w_rd ? w_rd_val : 32'd0;
         r_mtime   <= w_mtime_nxt;
         r_irq     <= r_pending && r_ctrl[CTRL_IRQ_EN];
         r_pending <= w_set || (r_pending && !w_w1c);
         if (w_rd && w_off == REG_MTIME_LO) r_hi_shadow <= r_mtime[63:32];
         if (w_wr) begin
            case (w_off)
               REG_CTRL:     r_ctrl            <= w_ctrl_mrg[2:0];
               REG_PRESCALE: r_prescale        <= w_pre_mrg[PRESCALE_W-1:0];
               REG_CMP_LO:   r_cmp[31:0]       <= byte_merge(r_cmp[31:0], wdata, wmask);
               REG_CMP_HI:   r_cmp[63:32]      <= byte_merge(r_cmp[63:32], wdata, wmask);
               default: ;
            endcase
         end
      end
   end

endmodule
